// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command parser.
// Holds the parser FSM encoding, the default sync marker and opcodes.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        HUNT,
        OPCODE,
        PAYLOAD,
        CHECK
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

    // CORDIC engine command set
    localparam logic [7:0] OP_SINCOS = 8'h01;
    localparam logic [7:0] OP_ATAN   = 8'h02;
    localparam logic [7:0] OP_MAG    = 8'h03;

endpackage

// File: rtl/uart_cmd_parser.sv
// Frames UART bytes into checksummed commands with a one-deep output
// register, inter-byte timeout and parity-error abort.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC,
    parameter int         PAYLOAD_BYTES  = 4,
    parameter int         TIMEOUT_CYCLES = 100_000
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [7:0]                 i_rx_byte,
    input  logic                       i_rx_byte_valid,
    input  logic                       i_rx_err,
    output logic [7:0]                 o_cmd_opcode,
    output logic [8*PAYLOAD_BYTES-1:0] o_cmd_data,
    output logic                       o_cmd_valid,
    input  logic                       i_cmd_ready,
    output logic                       o_frame_err,
    output logic                       o_overflow
);

    localparam int IDX_W  = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam int TCNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);
    localparam logic [TCNT_W-1:0] TLIM     = TCNT_W'(TIMEOUT_CYCLES - 1);

    state_t                     state, state_d;
    logic [IDX_W-1:0]           idx, idx_d;
    logic [7:0]                 xor_q, xor_d;
    logic [TCNT_W-1:0]          tcnt, tcnt_d;
    logic [7:0]                 op_sh, op_d;
    logic [8*PAYLOAD_BYTES-1:0] data_sh, data_d;
    logic                       err_d;
    logic                       done;
    logic                       load;

    always_comb begin
        state_d = state;
        idx_d   = idx;
        xor_d   = xor_q;
        tcnt_d  = tcnt;
        op_d    = op_sh;
        data_d  = data_sh;
        err_d   = 1'b0;
        done    = 1'b0;
        if (state == HUNT) begin
            tcnt_d = '0;
            if (i_rx_byte_valid && i_rx_byte == SYNC_BYTE) begin
                state_d = OPCODE;
            end
        end else if (i_rx_err) begin
            state_d = HUNT;
            idx_d   = '0;
            tcnt_d  = '0;
            err_d   = 1'b1;
        end else if (i_rx_byte_valid) begin
            tcnt_d = '0;
            unique case (state)
                OPCODE: begin
                    op_d    = i_rx_byte;
                    xor_d   = i_rx_byte;
                    idx_d   = '0;
                    state_d = PAYLOAD;
                end
                PAYLOAD: begin
                    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
                        if (idx == IDX_W'(i)) begin
                            data_d[i*8 +: 8] = i_rx_byte;
                        end
                    end
                    xor_d = xor_q ^ i_rx_byte;
                    if (idx == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = CHECK;
                    end else begin
                        idx_d = idx + IDX_W'(1);
                    end
                end
                CHECK: begin
                    state_d = HUNT;
                    done    = (i_rx_byte == xor_q);
                    err_d   = (i_rx_byte != xor_q);
                end
                default: state_d = HUNT;
            endcase
        end else if (tcnt == TLIM) begin
            state_d = HUNT;
            idx_d   = '0;
            tcnt_d  = '0;
            err_d   = 1'b1;
        end else begin
            tcnt_d = tcnt + TCNT_W'(1);
        end
    end

    // A completed frame only loads when the output slot is free or draining
    assign load = done && (!o_cmd_valid || i_cmd_ready);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= HUNT;
            idx   <= '0;
            xor_q <= '0;
            tcnt  <= '0;
            op_sh <= '0;
            data_sh <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            xor_q <= xor_d;
            tcnt  <= tcnt_d;
            op_sh <= op_d;
            data_sh <= data_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_cmd_opcode <= '0;
            o_cmd_data   <= '0;
            o_cmd_valid  <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overflow   <= 1'b0;
        end else begin
            o_frame_err <= err_d;
            o_overflow  <= done && o_cmd_valid && !i_cmd_ready;
            if (load) begin
                o_cmd_opcode <= op_sh;
                o_cmd_data   <= data_sh;
                o_cmd_valid  <= 1'b1;
            end else if (o_cmd_valid && i_cmd_ready) begin
                o_cmd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: frame table plus overflow,
// parity-abort, timeout and reset sequences.
module tb_uart_cmd_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_byte = '0;
    logic        rx_valid = 1'b0;
    logic        rx_err = 1'b0;
    logic [7:0]  cmd_opcode;
    logic [31:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic        frame_err;
    logic        overflow;

    int tests = 0;
    int fails = 0;

    uart_cmd_parser #(
        .SYNC_BYTE(8'hA5),
        .PAYLOAD_BYTES(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_rx_byte(rx_byte),
        .i_rx_byte_valid(rx_valid),
        .i_rx_err(rx_err),
        .o_cmd_opcode(cmd_opcode),
        .o_cmd_data(cmd_data),
        .o_cmd_valid(cmd_valid),
        .i_cmd_ready(cmd_ready),
        .o_frame_err(frame_err),
        .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] data;
        logic [7:0]  chk;
        logic        ok;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] d,
                              input logic [7:0] chk, input logic rdy);
        send_byte(8'hA5);
        send_byte(op);
        for (int i = 0; i < 4; i++) send_byte(d[i*8 +: 8]);
        @(negedge clk);
        rx_byte   = chk;
        rx_valid  = 1'b1;
        cmd_ready = rdy;
        @(negedge clk);
        rx_valid  = 1'b0;
        cmd_ready = 1'b0;
    endtask

    task automatic consume();
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        check("consume_valid_clr", cmd_valid, 0);
    endtask

    initial begin
        int hit;
        vecs[0] = '{8'h01, 32'h44332211, 8'h45, 1'b1};
        vecs[1] = '{8'h01, 32'h44332211, 8'h46, 1'b0};
        vecs[2] = '{8'h02, 32'hA5A5A5A5, 8'h02, 1'b1};
        vecs[3] = '{8'h03, 32'h00000000, 8'h03, 1'b1};
        vecs[4] = '{8'hFF, 32'h12345678, 8'hF7, 1'b1};
        vecs[5] = '{8'h10, 32'hDEADBEEF, 8'h32, 1'b1};

        repeat (2) @(negedge clk);
        check("rst_valid", cmd_valid, 0);
        check("rst_opcode", cmd_opcode, 0);
        check("rst_data", cmd_data, 0);
        check("rst_err", frame_err, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].op, vecs[v].data, vecs[v].chk, 1'b0);
            check($sformatf("v%0d_valid", v), cmd_valid, vecs[v].ok);
            check($sformatf("v%0d_err", v), frame_err, !vecs[v].ok);
            if (vecs[v].ok) begin
                check($sformatf("v%0d_op", v), cmd_opcode, vecs[v].op);
                check($sformatf("v%0d_data", v), cmd_data, vecs[v].data);
                consume();
            end else begin
                @(negedge clk);
                check($sformatf("v%0d_err_pulse", v), frame_err, 0);
            end
        end

        // overflow then reload on same-cycle handshake
        send_frame(8'h01, 32'h44332211, 8'h45, 1'b0);
        check("ovf_first_valid", cmd_valid, 1);
        send_frame(8'h03, 32'h0, 8'h03, 1'b0);
        check("ovf_pulse", overflow, 1);
        check("ovf_held_op", cmd_opcode, 8'h01);
        check("ovf_held_data", cmd_data, 32'h44332211);
        @(negedge clk);
        check("ovf_pulse_end", overflow, 0);
        send_frame(8'hFF, 32'h12345678, 8'hF7, 1'b1);
        check("reload_valid", cmd_valid, 1);
        check("reload_op", cmd_opcode, 8'hFF);
        check("reload_data", cmd_data, 32'h12345678);
        check("reload_no_ovf", overflow, 0);
        consume();

        // parity error in HUNT is ignored
        @(negedge clk);
        rx_err = 1'b1;
        @(negedge clk);
        rx_err = 1'b0;
        check("hunt_err_ignored", frame_err, 0);

        // parity error on third payload byte
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        @(negedge clk);
        rx_byte  = 8'h33;
        rx_valid = 1'b1;
        rx_err   = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_err   = 1'b0;
        check("rxerr_pulse", frame_err, 1);
        @(negedge clk);
        check("rxerr_pulse_end", frame_err, 0);
        send_byte(8'h00);
        send_byte(8'hFF);
        check("garbage_no_err", frame_err, 0);
        check("garbage_no_valid", cmd_valid, 0);
        send_frame(8'h02, 32'h04030201, 8'h06, 1'b0);
        check("after_rxerr_valid", cmd_valid, 1);
        check("after_rxerr_data", cmd_data, 32'h04030201);
        consume();

        // gap below the limit survives
        send_byte(8'hA5);
        repeat (10) @(negedge clk);
        send_byte(8'h03);
        for (int i = 0; i < 4; i++) send_byte(8'h00);
        send_byte(8'h03);
        check("short_gap_valid", cmd_valid, 1);
        consume();

        // inter-byte timeout
        send_byte(8'hA5);
        send_byte(8'h02);
        hit = 41;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (frame_err) begin
                hit = i;
                break;
            end
        end
        check("timeout_cycles", hit, 16);
        @(negedge clk);
        check("timeout_pulse_end", frame_err, 0);

        // reset mid-frame with a held command
        send_frame(8'h01, 32'h44332211, 8'h45, 1'b0);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h11);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_valid", cmd_valid, 0);
        check("midrst_op", cmd_opcode, 0);
        check("midrst_data", cmd_data, 0);
        check("midrst_err", frame_err, 0);
        check("midrst_ovf", overflow, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h45);
        check("postrst_no_valid", cmd_valid, 0);
        check("postrst_no_err", frame_err, 0);
        send_frame(8'h10, 32'hDEADBEEF, 8'h32, 1'b0);
        check("postrst_valid", cmd_valid, 1);
        check("postrst_op", cmd_opcode, 8'h10);
        consume();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
